// File: rtl/cnt_seq_pkg.sv
// Shared mode encoding and mode-advance helper for the LED counter sequencer.
package cnt_seq_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_MANUAL    = 2'd0;
    localparam logic [MODE_W-1:0] MODE_AUTO_UP   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_AUTO_DOWN = 2'd2;
    localparam logic [MODE_W-1:0] MODE_PAUSE     = 2'd3;

    // Button order MANUAL -> AUTO_UP -> AUTO_DOWN -> PAUSE -> MANUAL
    function automatic logic [MODE_W-1:0] mode_advance(input logic [MODE_W-1:0] m);
        return MODE_W'(m + 2'd1);
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce and its DB_CYCLES parameter exist only when CNT_SEQ_DEBOUNCE_EN is defined.
module btn_cond
`ifdef CNT_SEQ_DEBOUNCE_EN
#(
    parameter int unsigned DB_CYCLES = 1000000
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise_c
);

    logic [1:0] sync;
    logic       lvl_c;
    logic       prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn};
        end
    end

`ifdef CNT_SEQ_DEBOUNCE_EN
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    logic [DW-1:0] db_cnt;
    logic          db_lvl;

    // Level follows the synced input only after DB_CYCLES consecutive differing cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            db_lvl <= 1'b0;
        end else if (sync[1] != db_lvl) begin
            if (db_cnt == DW'(DB_CYCLES - 1)) begin
                db_lvl <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign lvl_c = db_lvl;
`else
    assign lvl_c = sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= lvl_c;
        end
    end

    assign rise_c = lvl_c & ~prev;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the 4-bit LED up/down counter: prescaler tick plus mode FSM issuing inc/dec strobes.
// Optional mode_btn debounce (and the DB_CYCLES parameter) enabled by CNT_SEQ_DEBOUNCE_EN.
module counter_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000000,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 15
`ifdef CNT_SEQ_DEBOUNCE_EN
    ,
    parameter int unsigned DB_CYCLES = 1000000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up,
    input  logic              down,
    input  logic              mode_btn,
    input  logic [WIDTH-1:0]  cnt_val,
    output logic              tick,
    output logic              inc,
    output logic              dec,
    output logic [MODE_W-1:0] mode
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]     presc;
    logic              tc_c;
    logic              btn_rise_c;
    logic [MODE_W-1:0] mode_nxt;
    logic              inc_nxt;
    logic              dec_nxt;

    assign tc_c = (presc == PW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tc_c) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

`ifdef CNT_SEQ_DEBOUNCE_EN
    btn_cond #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn    (mode_btn),
        .rise_c (btn_rise_c)
    );
`else
    btn_cond u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn    (mode_btn),
        .rise_c (btn_rise_c)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= MODE_MANUAL;
            tick <= 1'b0;
            inc  <= 1'b0;
            dec  <= 1'b0;
        end else begin
            mode <= mode_nxt;
            tick <= tc_c;
            inc  <= inc_nxt;
            dec  <= dec_nxt;
        end
    end

    // Strobe uses the current mode; a button edge overrides any bounce turnaround
    always_comb begin
        mode_nxt = mode;
        inc_nxt  = 1'b0;
        dec_nxt  = 1'b0;
        if (tc_c) begin
            case (mode)
                MODE_MANUAL: begin
                    if (up) begin
                        inc_nxt = 1'b1;
                    end else if (down) begin
                        dec_nxt = 1'b1;
                    end
                end
                MODE_AUTO_UP: begin
                    if (cnt_val < WIDTH'(MAX_VAL)) begin
                        inc_nxt = 1'b1;
                    end else begin
                        dec_nxt  = 1'b1;
                        mode_nxt = MODE_AUTO_DOWN;
                    end
                end
                MODE_AUTO_DOWN: begin
                    if (cnt_val != '0) begin
                        dec_nxt = 1'b1;
                    end else begin
                        inc_nxt  = 1'b1;
                        mode_nxt = MODE_AUTO_UP;
                    end
                end
                default: begin
                end
            endcase
        end
        if (btn_rise_c) begin
            mode_nxt = mode_advance(mode);
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl; also covers the CNT_SEQ_DEBOUNCE_EN build.
module tb_counter_seq_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MAX_VAL = 15;
`ifdef CNT_SEQ_DEBOUNCE_EN
    localparam int unsigned DB_CYCLES = 8;
    localparam int BTN_LAT = 2 + DB_CYCLES + 1;
`else
    localparam int BTN_LAT = 3;
`endif

    typedef struct packed {
        logic       inc;
        logic       dec;
        logic [1:0] mode;
    } tick_exp_t;

    typedef struct {
        logic [1:0] mode;
        int         cyc;
        bit         chk;
    } mode_exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             up = 1'b0;
    logic             down = 1'b0;
    logic             mode_btn = 1'b0;
    logic [WIDTH-1:0] cnt_val = '0;
    logic             tick;
    logic             inc;
    logic             dec;
    logic [1:0]       mode;

    tick_exp_t tq[$];
    mode_exp_t mq[$];

    int         checks = 0;
    int         errors = 0;
    int         gcyc = 0;
    int         last_tick = 0;
    logic [1:0] last_mode = 2'd0;

    counter_seq_ctrl #(
        .CLK_DIV (CLK_DIV),
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
`ifdef CNT_SEQ_DEBOUNCE_EN
        ,
        .DB_CYCLES (DB_CYCLES)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .mode_btn (mode_btn),
        .cnt_val  (cnt_val),
        .tick     (tick),
        .inc      (inc),
        .dec      (dec),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) gcyc <= gcyc + 1;

    // Monitor: strobe guard every cycle, scoreboard pop on each tick and each mode change
    always @(negedge clk) begin
        tick_exp_t te;
        mode_exp_t me;
        if (rst) begin
            last_mode = mode;
        end else begin
            checks++;
            if (((inc | dec) && !tick) || (inc && dec)) begin
                errors++;
                $display("FAIL strobe_guard cyc=%0d: tick=%0b inc=%0b dec=%0b, required no strobe off-tick and never both",
                         gcyc, tick, inc, dec);
            end
            if (tick) begin
                checks++;
                if (gcyc - last_tick != int'(CLK_DIV)) begin
                    errors++;
                    $display("FAIL tick_period cyc=%0d: got %0d cycles, required %0d", gcyc, gcyc - last_tick, CLK_DIV);
                end
                last_tick = gcyc;
                checks++;
                if (tq.size() > 0) begin
                    te = tq.pop_front();
                    if ({inc, dec, mode} !== {te.inc, te.dec, te.mode}) begin
                        errors++;
                        $display("FAIL tick_strobe cyc=%0d: got inc=%0b dec=%0b mode=%0d, required inc=%0b dec=%0b mode=%0d",
                                 gcyc, inc, dec, mode, te.inc, te.dec, te.mode);
                    end
                end else if (inc || dec) begin
                    errors++;
                    $display("FAIL idle_tick cyc=%0d: got inc=%0b dec=%0b, required no strobe", gcyc, inc, dec);
                end
            end
            if (mode != last_mode) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL mode_change cyc=%0d: got unexpected change %0d->%0d, required no change", gcyc, last_mode, mode);
                end else begin
                    me = mq.pop_front();
                    if (mode != me.mode || (me.chk && gcyc != me.cyc)) begin
                        errors++;
                        $display("FAIL mode_change: got mode=%0d at cyc %0d, required mode=%0d at cyc %0d",
                                 mode, gcyc, me.mode, me.chk ? me.cyc : gcyc);
                    end
                end
                last_mode = mode;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_tick(input logic i, input logic d, input logic [1:0] m);
        tick_exp_t te;
        te.inc  = i;
        te.dec  = d;
        te.mode = m;
        tq.push_back(te);
    endtask

    task automatic push_mode(input logic [1:0] m, input int c, input bit chk);
        mode_exp_t me;
        me.mode = m;
        me.cyc  = c;
        me.chk  = chk;
        mq.push_back(me);
    endtask

    // Returns 1 time unit after the negedge on which tick is seen
    task automatic align_tick();
        for (int i = 0; i < int'(4 * CLK_DIV); i++) begin
            @(negedge clk);
            if (tick) break;
        end
        checks++;
        if (!tick) begin
            errors++;
            $display("FAIL tick_timeout: got tick=0 after %0d cycles, required tick=1", 4 * CLK_DIV);
        end
        #1;
    endtask

    task automatic step(input logic i, input logic d, input logic [1:0] m, input logic [WIDTH-1:0] nc);
        push_tick(i, d, m);
        align_tick();
        cnt_val = nc;
    endtask

    initial begin
        int base;
        int n_idle;

        repeat (3) @(negedge clk);
        #1;
        check("reset_tick", int'(tick), 0);
        check("reset_inc", int'(inc), 0);
        check("reset_dec", int'(dec), 0);
        check("reset_mode", int'(mode), 0);
        rst = 1'b0;
        last_tick = gcyc;

        // Idle MANUAL: ticks only
        repeat (3) align_tick();

        // Manual requests, up has priority
        up = 1'b1; down = 1'b1; cnt_val = 4'd7;
        step(1'b1, 1'b0, 2'd0, 4'd7);
        step(1'b1, 1'b0, 2'd0, 4'd7);
        up = 1'b0;
        step(1'b0, 1'b1, 2'd0, 4'd7);
        step(1'b0, 1'b1, 2'd0, 4'd7);
        up = 1'b1; down = 1'b0; cnt_val = 4'd0;
        step(1'b1, 1'b0, 2'd0, 4'd0);
        up = 1'b0;

`ifndef CNT_SEQ_DEBOUNCE_EN
        // Four quick presses: modes change 3 cycles after each rise
        cnt_val = 4'd7;
        base = gcyc;
        push_tick(1'b1, 1'b0, 2'd1);
        push_tick(1'b0, 1'b0, 2'd3);
        push_mode(2'd1, base + 3, 1'b1);
        push_mode(2'd2, base + 5, 1'b1);
        push_mode(2'd3, base + 7, 1'b1);
        push_mode(2'd0, base + 9, 1'b1);
        for (int i = 0; i < 8; i++) begin
            mode_btn = (i % 2 == 0);
            @(negedge clk);
            #1;
        end
        check("fast_press_drain", tq.size(), 0);
        align_tick();
`endif

        // Held button: one advance into AUTO_UP, then bounce at MAX_VAL and at 0
        cnt_val = 4'd13;
        mode_btn = 1'b1;
        base = gcyc;
        n_idle = (BTN_LAT - 1) / int'(CLK_DIV);
        for (int k = 0; k < n_idle; k++) push_tick(1'b0, 1'b0, 2'd0);
        push_mode(2'd1, base + BTN_LAT, 1'b1);
        repeat (n_idle) align_tick();
        step(1'b1, 1'b0, 2'd1, 4'd14);
        mode_btn = 1'b0;
        step(1'b1, 1'b0, 2'd1, 4'd15);
        push_mode(2'd2, 0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 4'd1);
        step(1'b0, 1'b1, 2'd2, 4'd0);
        push_mode(2'd1, 0, 1'b0);
        step(1'b1, 1'b0, 2'd1, 4'd1);

`ifndef CNT_SEQ_DEBOUNCE_EN
        // Button edge on terminal count at MAX_VAL: dec issued, single advance to AUTO_DOWN
        cnt_val = 4'd15;
        @(negedge clk);
        #1;
        mode_btn = 1'b1;
        push_mode(2'd2, gcyc + 3, 1'b1);
        push_tick(1'b0, 1'b1, 2'd2);
        align_tick();
        mode_btn = 1'b0;
        cnt_val = 4'd14;
        @(negedge clk);
        #1;
        mode_btn = 1'b1;
        push_mode(2'd3, gcyc + 3, 1'b1);
        push_tick(1'b0, 1'b1, 2'd3);
        align_tick();
        mode_btn = 1'b0;
        cnt_val = 4'd13;
        step(1'b0, 1'b0, 2'd3, 4'd13);
`endif

        // Asynchronous reset while tick (and any strobe) is high
        rst = 1'b1;
        #1;
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_inc", int'(inc), 0);
        check("async_rst_dec", int'(dec), 0);
        check("async_rst_mode", int'(mode), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        last_tick = gcyc;
        repeat (2) align_tick();

`ifdef CNT_SEQ_DEBOUNCE_EN
        // Short glitch is filtered out
        mode_btn = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        mode_btn = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("glitch_mode", int'(mode), 0);
`endif

        check("tick_queue_empty", tq.size(), 0);
        check("mode_queue_empty", mq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
